// File: rtl/note_lane_renderer.sv
// note_lane_renderer
//   Note-highway renderer. Keeps a LANES x SLOTS grid of 2-bit note cells as
//   per-lane shift registers. A beat shifts the song by one slot and redraws
//   every box pixel by pixel through the VGA plot port. A clear empties the grid
//   and paints every box in BG_COLOUR. One beat and one clear request can be
//   buffered while a pass is running.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   beat, clear    single-cycle requests
//   note_in        new slot-0 contents, lane l at [2l+1:2l]
//                  (00 empty, 01 tap, 10 hold, 11 tap)
//   sprite_addr    {py, px} sprite ROM address
//   sprite_sel     0 tap sprite, 1 hold sprite
//   sprite_colour  ROM data, one cycle after address
//   vga_x, vga_y, vga_colour, vga_plot   pixel write port
//   busy           high whenever not IDLE
//   frame_done     one-cycle pulse at the end of each pass
//   overrun        one-cycle pulse when a beat is dropped
//   hit_zone       contents of slot SLOTS-1
module note_lane_renderer #(
    parameter int         LANES     = 3,
    parameter int         SLOTS     = 4,
    parameter int         BOX       = 60,
    parameter int         ORIGIN_X  = 0,
    parameter int         ORIGIN_Y  = 60,
    parameter logic [2:0] BG_COLOUR = 3'b111
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 beat,
    input  logic                 clear,
    input  logic [2*LANES-1:0]   note_in,
    output logic [11:0]          sprite_addr,
    output logic                 sprite_sel,
    input  logic [2:0]           sprite_colour,
    output logic [8:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [2*LANES-1:0]   hit_zone
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT, DRAW, CLEAR, DONE} state_t;

    state_t                          state, state_nxt;
    logic [LANES-1:0][SLOTS-1:0][1:0] grid;
    logic                            pend_beat, pend_clear;
    logic                            take_beat, take_clear;
    logic [LW-1:0]                   lane;
    logic [SW-1:0]                   slot;
    logic [5:0]                      px, py;
    logic                            scan_done;
    logic                            vld_p0;
    logic [1:0]                      cell_p0;
    logic                            plot_p1, bg_p1;
    logic [8:0]                      x_p1;
    logic [7:0]                      y_p1;
    logic                            overrun_r;

    // A clear wins over a beat; a beat arriving alongside a clear stays pending.
    always_comb begin
        state_nxt  = state;
        take_clear = 1'b0;
        take_beat  = 1'b0;
        case (state)
            IDLE: begin
                if (clear || pend_clear) begin
                    take_clear = 1'b1;
                    state_nxt  = CLEAR;
                end else if (beat || pend_beat) begin
                    take_beat = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT:       state_nxt = DRAW;
            DRAW, CLEAR: if (scan_done) state_nxt = DONE;
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Stage p0: the scan position is issued to the ROM combinationally.
    // scan_done marks the drain cycle in which only the last plot is pending.
    assign vld_p0      = ((state == DRAW) || (state == CLEAR)) && !scan_done;
    assign cell_p0     = grid[lane][slot];
    assign sprite_addr = vld_p0 ? {py, px} : 12'd0;
    assign sprite_sel  = vld_p0 && (state == DRAW) && (cell_p0 == 2'b10);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grid       <= '0;
            pend_beat  <= 1'b0;
            pend_clear <= 1'b0;
            overrun_r  <= 1'b0;
            lane       <= '0;
            slot       <= '0;
            px         <= '0;
            py         <= '0;
            scan_done  <= 1'b0;
            plot_p1    <= 1'b0;
            x_p1       <= '0;
            y_p1       <= '0;
        end else begin
            state <= state_nxt;

            if (take_clear)
                pend_clear <= 1'b0;
            else if (clear)
                pend_clear <= 1'b1;

            // A beat that arrives as the pending one is consumed takes its place.
            if (take_beat)
                pend_beat <= pend_beat && beat;
            else if (beat)
                pend_beat <= 1'b1;
            overrun_r <= beat && pend_beat && !take_beat;

            if (take_clear) begin
                grid <= '0;
            end else if (state == SHIFT) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int s = SLOTS - 1; s > 0; s--)
                        grid[l][s] <= grid[l][s-1];
                    grid[l][0] <= note_in[2*l +: 2];
                end
            end

            // Scan order: lane, slot, py, px (px fastest).
            if (vld_p0) begin
                if (px == 6'(BOX - 1)) begin
                    px <= '0;
                    if (py == 6'(BOX - 1)) begin
                        py <= '0;
                        if (slot == SW'(SLOTS - 1)) begin
                            slot <= '0;
                            if (lane == LW'(LANES - 1)) begin
                                lane      <= '0;
                                scan_done <= 1'b1;
                            end else begin
                                lane <= lane + 1'b1;
                            end
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end else begin
                        py <= py + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end
            end else if (state == DONE) begin
                scan_done <= 1'b0;
            end

            // Stage p1: pixel coordinates line up with the ROM data.
            plot_p1 <= vld_p0;
            if (vld_p0) begin
                x_p1 <= 9'(ORIGIN_X) + 9'(slot) * 9'(BOX) + 9'(px);
                y_p1 <= 8'(ORIGIN_Y) + 8'(lane) * 8'(BOX) + 8'(py);
            end
        end
    end

    always_ff @(posedge clock) begin
        bg_p1 <= (state == CLEAR) || (cell_p0 == 2'b00);
    end

    always_comb begin
        hit_zone = '0;
        for (int l = 0; l < LANES; l++)
            hit_zone[2*l +: 2] = grid[l][SLOTS-1];
    end

    assign vga_plot   = plot_p1;
    assign vga_x      = x_p1;
    assign vga_y      = y_p1;
    assign vga_colour = plot_p1 ? (bg_p1 ? BG_COLOUR : sprite_colour) : 3'd0;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign overrun    = overrun_r;

endmodule

// File: doc/note_lane_renderer.md
# note_lane_renderer

Parametrised note-highway renderer for the theremin-hero display. Holds a LANES x SLOTS grid of note cells as per-lane shift registers. On each beat it advances the song by one slot and redraws every box through the VGA plot port, one pixel per cycle, using a 64x64 sprite ROM. Unlike the previous fixed 3x4 datapath, it runs its own control FSM, supports tap and hold note types, buffers one beat/clear request while busy, and exports the hit-zone column to scoring.

## Interface
- LANES, 3: number of note lanes; each lane is one box-row on screen.
- SLOTS, 4: visible time slots per lane; each slot is one box-column.
- BOX, 60: box edge in pixels, 1..64.
- ORIGIN_X, 0: screen X of the grid's left edge.
- ORIGIN_Y, 60: screen Y of the grid's top edge.
- BG_COLOUR, 3'b111: colour of empty cells and of clear.
- Constraints: ORIGIN_X+SLOTS*BOX ≤ 320; ORIGIN_Y+LANES*BOX ≤ 240.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- beat  in  1  single-cycle request to shift the song and redraw.
- clear  in  1  single-cycle request to empty the grid and paint BG_COLOUR.
- note_in  in  2*LANES  new slot-0 contents, lane l at [2l+1:2l]. 00 empty, 01 tap, 10 hold, 11 treated as tap. Sampled in the SHIFT cycle.
- sprite_addr  out  12  {py[5:0], px[5:0]} sprite ROM address.
- sprite_sel  out  1  0 = tap sprite, 1 = hold sprite.
- sprite_colour  in  3  ROM data, valid one cycle after sprite_addr/sprite_sel.
- vga_x  out  9, vga_y  out  8, vga_colour  out  3  pixel to plot.
- vga_plot  out  1  write enable for the VGA adapter.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse at the end of every SHIFT/DRAW or CLEAR pass.
- overrun  out  1  one-cycle pulse when a request is dropped.
- hit_zone  out  2*LANES  registered contents of slot SLOTS-1, in note_in encoding.

## Operation
- Grid: cell(l,s) is 2 bits. Slot 0 is the newest and is drawn leftmost; slot SLOTS-1 is the hit zone and is drawn rightmost.
- Cell placement: pixel x = ORIGIN_X + s*BOX + px; y = ORIGIN_Y + l*BOX + py. Compute in 9/8 bits; the parameter constraints guarantee no overflow.
- FSM states: IDLE, SHIFT, DRAW, CLEAR, DONE.
- IDLE:
  - If clear (or a pending clear) is present, go to CLEAR.
  - Otherwise, if beat (or a pending beat) is present, go to SHIFT.
  - Consuming a request clears its pending flag.
- SHIFT (1 cycle): for every lane, cell(l,s) ← cell(l,s-1) and cell(l,0) ← note_in lane l. The old slot SLOTS-1 is discarded. hit_zone updates to the new slot SLOTS-1 on the same edge. Next state: DRAW.
- DRAW: scan cells in lane-major, slot-minor order; within a cell scan py-major, px-minor, from 0 to BOX-1.
  - Each scan cycle issues sprite_addr and sprite_sel (1 for hold).
  - One cycle later the pipeline stage drives vga_x/vga_y and vga_plot=1.
  - vga_colour is sprite_colour for tap/hold cells and BG_COLOUR for empty cells.
  - After the final pipelined plot, go to DONE.
- CLEAR: all cells ← 00 and hit_zone ← 0 on entry. Then the same scan and pipeline as DRAW runs with vga_colour = BG_COLOUR, ignoring sprite data. Then go to DONE.
- DONE (1 cycle): frame_done=1, then IDLE.
- Request buffering while busy:
  - beat sets pend_beat; a beat while pend_beat is already set → overrun pulse, beat dropped.
  - clear sets pend_clear; a repeat clear is silently merged.
  - A pending clear is served before a pending beat.
- Simultaneous beat and clear in IDLE: CLEAR runs and the beat becomes pending.
- Reset, including mid-pass: state IDLE, grid empty, pending flags 0. All outputs 0 (sprite_addr, sprite_sel, vga_*, busy, frame_done, overrun, hit_zone). The partial frame is abandoned; no automatic clear is performed.

## Timing
- A beat sampled at edge 0 in IDLE puts the FSM in SHIFT at edge 1, with busy=1 from then on.
- DRAW issues its first address at edge 2; the first vga_plot occurs at edge 3.
- Pass length is P = LANES*SLOTS*BOX*BOX plots, exactly one per cycle with no gaps. The last plot is at edge 2+P, DONE at edge 3+P, and IDLE at edge 4+P.
- CLEAR from IDLE: first plot one cycle after entering CLEAR. Cycle count is the same as DRAW, minus the SHIFT cycle.
- A pending request starts SHIFT/CLEAR on the cycle after IDLE is re-entered (IDLE lasts 1 cycle).
- vga_plot is never high outside DRAW/CLEAR pipeline cycles.

## Test plan
- Reset then clear (defaults): 43200 plots, all colour 3'b111, x 0..239, y 60..239. frame_done exactly 43202 cycles after clear is sampled.
- Beat with note_in=6'b00_10_01 (lane0 tap, lane1 hold) and ROM returning 3'b100 for tap, 3'b010 for hold:
  - box at (0,60) plots 3'b100 with sprite_sel=0;
  - box at (0,120) plots 3'b010 with sprite_sel=1;
  - all other boxes plot 3'b111.
- Four beats with lane0 tap on the first only: hit_zone=6'b000001 after the fourth SHIFT and 0 after the fifth.
- Two beats during one DRAW: the first is serviced immediately after DONE; the second pulses overrun and is never drawn.
- Beat and clear in the same IDLE cycle: CLEAR pass, then SHIFT/DRAW pass.
- Assert reset mid-DRAW (pixel 1000): all outputs 0 at once, busy low. A following beat draws from an empty grid.
